// File: rtl/stage3_mdu_sequencer.sv
// Sequencer for the shared RV32M multiply/divide unit in EX: start, stall, hold, flush abort, timeout.
// Optional one-entry result cache enabled by defining MDU_RESULT_CACHE_EN.
module stage3_mdu_sequencer #(
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        mem_use_stall,
  input  logic        ex_mem_stall,
  input  logic        flush,
  output logic        fu_start,
  output logic        fu_abort,
  output logic [2:0]  fu_op,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  input  logic        fu_done,
  input  logic [31:0] fu_out,
  output logic        ex_busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        fu_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t              state, state_nx;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q, result_q;
  logic [CNT_W-1:0]    cnt;
  logic                accept, capture, timeout, hit;
  logic [DATA_W-1:0]   hit_result;

`ifdef MDU_RESULT_CACHE_EN
  logic                cache_v;
  logic [2:0]          cache_op;
  logic [DATA_W-1:0]   cache_a, cache_b, cache_r;

  assign hit        = cache_v && (cache_op == op) && (cache_a == rs1) && (cache_b == rs2);
  assign hit_result = cache_r;

  // Remembers the last FU-computed result keyed by its operation and operands
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cache_v  <= 1'b0;
      cache_op <= '0;
      cache_a  <= '0;
      cache_b  <= '0;
      cache_r  <= '0;
    end else if (timeout) begin
      cache_v <= 1'b0;
    end else if (capture) begin
      cache_v  <= 1'b1;
      cache_op <= op_q;
      cache_a  <= a_q;
      cache_b  <= b_q;
      cache_r  <= fu_out;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    fu_start     = 1'b0;
    fu_abort     = 1'b0;
    fu_timeout   = 1'b0;
    ex_busy      = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (req && !mem_use_stall && !flush) begin
          accept  = 1'b1;
          ex_busy = 1'b1;
          if (hit) begin
            state_nx = HOLD;
          end else begin
            fu_start = 1'b1;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        ex_busy = 1'b1;
        // Flush wins over completion; completion wins over timeout
        if (flush) begin
          fu_abort = 1'b1;
          state_nx = IDLE;
        end else if (fu_done) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end else if (cnt == CNT_LAST) begin
          fu_abort   = 1'b1;
          fu_timeout = 1'b1;
          timeout    = 1'b1;
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        result_valid = 1'b1;
        if (!ex_mem_stall || flush) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latches, BUSY cycle counter and result register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= rs1;
        b_q  <= rs2;
        cnt  <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept && hit)  result_q <= hit_result;
      else if (capture)   result_q <= fu_out;
      else if (timeout)   result_q <= '0;
    end
  end

  assign fu_op  = (state == IDLE) ? op  : op_q;
  assign fu_a   = (state == IDLE) ? rs1 : a_q;
  assign fu_b   = (state == IDLE) ? rs2 : b_q;
  assign result = result_q;

endmodule

// File: tb/tb_stage3_mdu_sequencer.sv
// Self-checking bench for stage3_mdu_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model (cache model when MDU_RESULT_CACHE_EN).
module tb_stage3_mdu_sequencer;

  localparam int unsigned TO = 8;

  logic        CLK, RST;
  logic        req, mem_use_stall, ex_mem_stall, flush, fu_done;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, fu_out;
  logic        fu_start, fu_abort, ex_busy, result_valid, fu_timeout;
  logic [2:0]  fu_op;
  logic [31:0] fu_a, fu_b, result;

  int n_chk = 0;
  int n_fail = 0;

  // Model: age of the in-flight FU op (-1 none), whether a result is on show, and its value
  int          m_age;
  bit          m_pres;
  logic [31:0] m_res, m_a, m_b;
  logic [2:0]  m_op;
`ifdef MDU_RESULT_CACHE_EN
  bit          c_v;
  logic [2:0]  c_op;
  logic [31:0] c_a, c_b, c_r;
`endif

  stage3_mdu_sequencer #(.DONE_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .req(req), .op(op), .rs1(rs1), .rs2(rs2),
    .mem_use_stall(mem_use_stall), .ex_mem_stall(ex_mem_stall), .flush(flush),
    .fu_start(fu_start), .fu_abort(fu_abort), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
    .fu_done(fu_done), .fu_out(fu_out), .ex_busy(ex_busy), .result(result),
    .result_valid(result_valid), .fu_timeout(fu_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_age = -1; m_pres = 0; m_res = '0; m_a = '0; m_b = '0; m_op = '0;
`ifdef MDU_RESULT_CACHE_EN
    c_v = 0; c_op = '0; c_a = '0; c_b = '0; c_r = '0;
`endif
  endtask

  // Compare this cycle's outputs with the model, then advance the model by one clock
  task automatic model_step();
    bit idle, acc, hit, tmo_now;
    idle = (m_age < 0) && !m_pres;
    acc  = idle && req && !mem_use_stall && !flush;
    hit  = 0;
`ifdef MDU_RESULT_CACHE_EN
    hit  = c_v && (c_op == op) && (c_a == rs1) && (c_b == rs2);
`endif
    tmo_now = (m_age >= 0) && !flush && !fu_done && (m_age + 1 == int'(TO));
    chk("m_fu_start", fu_start, acc && !hit);
    chk("m_ex_busy", ex_busy, acc || (m_age >= 0));
    chk("m_fu_abort", fu_abort, ((m_age >= 0) && flush) || tmo_now);
    chk("m_fu_timeout", fu_timeout, tmo_now);
    chk("m_result_valid", result_valid, m_pres);
    chk("m_result", result, m_res);
    chk("m_fu_op", fu_op, idle ? op : m_op);
    chk("m_fu_a", fu_a, idle ? rs1 : m_a);
    chk("m_fu_b", fu_b, idle ? rs2 : m_b);
    if (acc) begin
      m_op = op; m_a = rs1; m_b = rs2;
`ifdef MDU_RESULT_CACHE_EN
      if (hit) begin m_res = c_r; m_pres = 1; end
      else m_age = 0;
`else
      m_age = 0;
`endif
    end else if (m_age >= 0) begin
      if (flush) m_age = -1;
      else if (fu_done) begin
        m_res = fu_out; m_age = -1; m_pres = 1;
`ifdef MDU_RESULT_CACHE_EN
        c_v = 1; c_op = m_op; c_a = m_a; c_b = m_b; c_r = fu_out;
`endif
      end else if (tmo_now) begin
        m_res = '0; m_age = -1; m_pres = 1;
`ifdef MDU_RESULT_CACHE_EN
        c_v = 0;
`endif
      end else m_age++;
    end else if (m_pres && (!ex_mem_stall || flush)) begin
      m_pres = 0;
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic mus, input logic ems, input logic fl, input logic dn, input logic [31:0] fo);
    req = r; op = o; rs1 = a; rs2 = b; mem_use_stall = mus;
    ex_mem_stall = ems; flush = fl; fu_done = dn; fu_out = fo;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic end_cyc();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      at_neg(); end_cyc();
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk("rst_fu_start", fu_start, 0);
    chk("rst_fu_abort", fu_abort, 0);
    chk("rst_fu_timeout", fu_timeout, 0);
    chk("rst_ex_busy", ex_busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_fu_op", fu_op, 0);
    chk("rst_fu_a", fu_a, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // MUL 7x6, done on the 3rd cycle after start; done during start cycle must be ignored
    drive(1, 3'd0, 7, 6, 0, 0, 0, 1, 32'hdead);
    at_neg(); chk("t1_start", fu_start, 1); chk("t1_busy0", ex_busy, 1); end_cyc();
    for (int k = 1; k <= 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      at_neg(); chk("t1_busy", ex_busy, 1); chk("t1_nostart", fu_start, 0); chk("t1_fu_a", fu_a, 7); end_cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 42);
    at_neg(); chk("t1_busy3", ex_busy, 1); chk("t1_rv_early", result_valid, 0); end_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t1_rv", result_valid, 1); chk("t1_result", result, 42); chk("t1_busy_hold", ex_busy, 0); end_cyc();
    at_neg(); chk("t1_rv_drop", result_valid, 0); chk("t1_result_keep", result, 42); end_cyc();

    // DIVU with EX/MEM stalled 5 cycles in HOLD; req left high must not re-issue
    drive(1, 3'd5, 64, 4, 0, 0, 0, 0, 0);
    at_neg(); chk("t2_start", fu_start, 1); end_cyc();
    drive(1, 3'd5, 64, 4, 0, 1, 0, 1, 32'h10);
    at_neg(); chk("t2_busy_nostart", fu_start, 0); end_cyc();
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'd5, 64, 4, 0, 1, 0, 0, 0);
      at_neg(); chk("t2_hold_rv", result_valid, 1); chk("t2_hold_res", result, 32'h10); chk("t2_no_restart", fu_start, 0); end_cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t2_last_rv", result_valid, 1); end_cyc();
    at_neg(); chk("t2_rv_drop", result_valid, 0); end_cyc();

    // DIV flushed on the 2nd BUSY cycle
    drive(1, 3'd4, 100, 5, 0, 0, 0, 0, 0);
    at_neg(); chk("t3_start", fu_start, 1); end_cyc();
    at_neg(); chk("t3_noabort", fu_abort, 0); end_cyc();
    drive(1, 3'd4, 100, 5, 0, 0, 1, 0, 0);
    at_neg(); chk("t3_abort", fu_abort, 1); end_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t3_idle_busy", ex_busy, 0); chk("t3_rv", result_valid, 0);
    chk("t3_abort_drop", fu_abort, 0); chk("t3_result_kept", result, 32'h10); end_cyc();

    // Hung FU: abort and timeout on BUSY cycle TO
    drive(1, 3'd3, 32'hffff_ffff, 2, 0, 0, 0, 0, 0);
    at_neg(); chk("t4_start", fu_start, 1); end_cyc();
    for (int k = 1; k <= int'(TO); k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      at_neg(); chk("t4_abort", fu_abort, k == int'(TO)); chk("t4_timeout", fu_timeout, k == int'(TO)); end_cyc();
    end
    at_neg(); chk("t4_rv", result_valid, 1); chk("t4_result", result, 0); end_cyc();
    at_neg(); chk("t4_rv_drop", result_valid, 0); end_cyc();

    // Load-use stall for two cycles, start only with third-cycle operands
    drive(1, 3'd1, 11, 22, 1, 0, 0, 0, 0);
    at_neg(); chk("t5_nostart1", fu_start, 0); chk("t5_nobusy1", ex_busy, 0); end_cyc();
    drive(1, 3'd1, 33, 44, 1, 0, 0, 0, 0);
    at_neg(); chk("t5_nostart2", fu_start, 0); end_cyc();
    drive(1, 3'd1, 55, 66, 0, 0, 0, 0, 0);
    at_neg(); chk("t5_start", fu_start, 1); chk("t5_a", fu_a, 55); chk("t5_b", fu_b, 66); end_cyc();
    drive(0, 0, 99, 98, 0, 0, 0, 1, 5);
    at_neg(); chk("t5_latched_a", fu_a, 55); end_cyc();
    idle_cycles(2);

`ifdef MDU_RESULT_CACHE_EN
    // REMU 100,7 twice back-to-back; second served from the cache
    drive(1, 3'd7, 100, 7, 0, 0, 0, 0, 0);
    at_neg(); chk("t6_start", fu_start, 1); end_cyc();
    drive(1, 3'd7, 100, 7, 0, 0, 0, 1, 2);
    at_neg(); end_cyc();
    drive(1, 3'd7, 100, 7, 0, 0, 0, 0, 0);
    at_neg(); chk("t6_hold_rv", result_valid, 1); end_cyc();
    at_neg(); chk("t6_hit_nostart", fu_start, 0); chk("t6_hit_busy", ex_busy, 1); end_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t6_rv", result_valid, 1); chk("t6_result", result, 2); end_cyc();
    idle_cycles(1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req           = ($urandom_range(0, 3) != 0);
      op            = 3'($urandom_range(0, 7));
      rs1           = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rs2           = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      mem_use_stall = ($urandom_range(0, 4) == 0);
      ex_mem_stall  = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      fu_done       = ($urandom_range(0, 5) == 0);
      fu_out        = $urandom;
      at_neg(); end_cyc();
    end

    // Reset while BUSY: immediate idle, no abort
    idle_cycles(12);
    drive(1, 3'd6, 77, 3, 0, 0, 0, 0, 0);
    at_neg(); chk("t7_start", fu_start, 1); end_cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("t7_busy", ex_busy, 1);
    RST = 1'b1;
    #1;
    chk("t7_rst_busy", ex_busy, 0);
    chk("t7_rst_abort", fu_abort, 0);
    chk("t7_rst_rv", result_valid, 0);
    chk("t7_rst_result", result, 0);
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
